// File: rtl/fetch_pc_unit_pkg.sv
// Shared encodings for the fetch PC unit: FSM states and redirect causes.
package pc_pkg;

   typedef enum logic [1:0] {
      PC_BOOT = 2'd0,
      PC_RUN  = 2'd1,
      PC_HALT = 2'd2
   } pc_state_e;

   typedef enum logic [1:0] {
      RD_NONE   = 2'd0,
      RD_TRAP   = 2'd1,
      RD_BRANCH = 2'd2
   } redirect_cause_e;

   function automatic logic is_redirect(input redirect_cause_e cause);
      return cause != RD_NONE;
   endfunction

endpackage

// File: rtl/fetch_pc_unit_redirect_sel.sv
// Combinational next-PC priority select: trap > EX branch > sequential advance > hold.
module pc_redirect_sel
   import pc_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_trap_req,
   input  logic [XLEN-1:0] i_trap_vec,
   input  logic            i_ex_taken,
   input  logic [XLEN-1:0] i_ex_alt_pc,
   input  logic            i_advance,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_pc_plus,
   output logic [XLEN-1:0] o_next_pc,
   output redirect_cause_e o_cause
);

   always_comb begin
      o_next_pc = i_pc;
      o_cause   = RD_NONE;
      if (i_trap_req) begin
         o_next_pc = i_trap_vec;
         o_cause   = RD_TRAP;
      end else if (i_ex_taken) begin
         o_next_pc = i_ex_alt_pc;
         o_cause   = RD_BRANCH;
      end else if (i_advance) begin
         o_next_pc = i_pc_plus;
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator with boot/run/halt FSM, redirect flush pulse and redirect counter.
// Optional macro PC_MISALIGN_CHECK_EN adds the registered F_misalign output.
module fetch_pc_unit
   import pc_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              INC      = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             trap_req,
   input  logic [XLEN-1:0]  trap_vec,
   input  logic             EX_taken,
   input  logic [XLEN-1:0]  EX_alt_pc,
   input  logic             stall_D,
   input  logic             halt_req,
   input  logic             F_ready,
   output logic             F_valid,
   output logic [XLEN-1:0]  F_pc,
   output logic [XLEN-1:0]  F_pc_plus,
   output logic             F_flush,
   output logic [CNT_W-1:0] redirect_cnt,
`ifdef PC_MISALIGN_CHECK_EN
   output logic             F_misalign,
`endif
   output pc_state_e        dbg_state
);

   // Handshake: a fetch is transferred when F_valid & F_ready; a redirect abandons any open request.
   pc_state_e        r_state;
   pc_state_e        w_next_state;
   logic [XLEN-1:0]  r_pc;
   logic             r_valid;
   logic             r_flush;
   logic [CNT_W-1:0] r_cnt;
   logic [XLEN-1:0]  w_pc_plus;
   logic [XLEN-1:0]  w_next_pc;
   redirect_cause_e  w_cause;
   logic             w_redirect;
   logic             w_advance;

   assign w_pc_plus  = r_pc + XLEN'(INC);
   assign w_advance  = (r_state == PC_RUN) && F_ready && !stall_D && !halt_req;
   assign w_redirect = is_redirect(w_cause);

   pc_redirect_sel #(.XLEN(XLEN)) u_sel (
      .i_trap_req  (trap_req),
      .i_trap_vec  (trap_vec),
      .i_ex_taken  (EX_taken),
      .i_ex_alt_pc (EX_alt_pc),
      .i_advance   (w_advance),
      .i_pc        (r_pc),
      .i_pc_plus   (w_pc_plus),
      .o_next_pc   (w_next_pc),
      .o_cause     (w_cause)
   );

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         PC_BOOT: w_next_state = PC_RUN;
         PC_RUN:  if (!w_redirect && halt_req) w_next_state = PC_HALT;
         PC_HALT: if (w_redirect || !halt_req) w_next_state = PC_RUN;
         default: w_next_state = PC_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= PC_BOOT;
         r_pc    <= RESET_PC;
         r_valid <= 1'b0;
         r_flush <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         r_pc    <= w_next_pc;
         r_valid <= (w_next_state == PC_RUN);
         r_flush <= w_redirect;
         if (w_redirect && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + 1'b1;
      end
   end

`ifdef PC_MISALIGN_CHECK_EN
   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);
   logic r_misalign;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_misalign <= 1'b0;
      else      r_misalign <= w_redirect && ((w_next_pc & ALIGN_MASK) != '0);
   end

   assign F_misalign = r_misalign;
`endif

   assign F_valid      = r_valid;
   assign F_pc         = r_pc;
   assign F_pc_plus    = w_pc_plus;
   assign F_flush      = r_flush;
   assign redirect_cnt = r_cnt;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus randomized run against a behavioural model.
module tb_fetch_pc_unit;
   import pc_pkg::*;

   localparam int CNT_W = 4;
   localparam int CMAX  = 15;

   logic             clk;
   logic             rst;
   logic             trap_req;
   logic [31:0]      trap_vec;
   logic             EX_taken;
   logic [31:0]      EX_alt_pc;
   logic             stall_D;
   logic             halt_req;
   logic             F_ready;
   logic             F_valid;
   logic [31:0]      F_pc;
   logic [31:0]      F_pc_plus;
   logic             F_flush;
   logic [CNT_W-1:0] redirect_cnt;
   logic             F_misalign;
   pc_state_e        dbg_state;

   int n_cmp;
   int n_fail;

   // behavioural model state
   logic [31:0] m_pc;
   logic        m_booting;
   logic        m_halted;
   logic        m_valid;
   logic        m_flush;
   int          m_cnt;
   logic        m_mis;

   fetch_pc_unit #(.XLEN(32), .INC(4), .RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .trap_req     (trap_req),
      .trap_vec     (trap_vec),
      .EX_taken     (EX_taken),
      .EX_alt_pc    (EX_alt_pc),
      .stall_D      (stall_D),
      .halt_req     (halt_req),
      .F_ready      (F_ready),
      .F_valid      (F_valid),
      .F_pc         (F_pc),
      .F_pc_plus    (F_pc_plus),
      .F_flush      (F_flush),
      .redirect_cnt (redirect_cnt),
`ifdef PC_MISALIGN_CHECK_EN
      .F_misalign   (F_misalign),
`endif
      .dbg_state    (dbg_state)
   );

`ifndef PC_MISALIGN_CHECK_EN
   assign F_misalign = 1'b0;
`endif

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_pc = 32'h0; m_booting = 1'b1; m_halted = 1'b0;
      m_valid = 1'b0; m_flush = 1'b0; m_cnt = 0; m_mis = 1'b0;
   endtask

   task automatic model_step();
      logic        redir;
      logic [31:0] tgt;
      redir = trap_req || EX_taken;
      tgt   = trap_req ? trap_vec : EX_alt_pc;
      if (redir) begin
         m_pc = tgt; m_booting = 1'b0; m_halted = 1'b0;
      end else if (m_booting) begin
         m_booting = 1'b0;
      end else if (m_halted) begin
         m_halted = halt_req;
      end else if (halt_req) begin
         m_halted = 1'b1;
      end else if (F_ready && !stall_D) begin
         m_pc = m_pc + 32'd4;
      end
      m_valid = !m_halted;
      m_flush = redir;
      if (redir && m_cnt < CMAX) m_cnt = m_cnt + 1;
      m_mis = redir && (tgt % 4 != 0);
   endtask

   // driver: advance the model with the applied inputs, then let one clock edge happen
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      trap_req = 1'b0; trap_vec = '0; EX_taken = 1'b0; EX_alt_pc = '0;
      stall_D = 1'b0; halt_req = 1'b0; F_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      clear_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (F_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h exp %h", F_pc, 32'h0); end
      n_cmp++; if (F_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", F_valid); end
      n_cmp++; if (F_flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b exp 0", F_flush); end
      n_cmp++; if (redirect_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d exp 0", redirect_cnt); end
      n_cmp++; if (dbg_state !== PC_BOOT) begin n_fail++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, PC_BOOT); end
      n_cmp++; if (F_misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b exp 0", F_misalign); end
   endtask

   task automatic test_boot_seq();
      logic [31:0] exp_pc[3];
      exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
      rst = 1'b1;
      #1;
      n_cmp++; if (F_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid: got %b exp 0", F_valid); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (F_valid !== 1'b1) begin n_fail++; $display("FAIL boot_run_valid[%0d]: got %b exp 1", i, F_valid); end
         n_cmp++; if (F_pc !== exp_pc[i]) begin n_fail++; $display("FAIL boot_pc[%0d]: got %h exp %h", i, F_pc, exp_pc[i]); end
      end
   endtask

   task automatic test_ready_hold();
      repeat (2) tick();
      n_cmp++; if (F_pc !== 32'h10) begin n_fail++; $display("FAIL hold_start: got %h exp %h", F_pc, 32'h10); end
      F_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (F_pc !== 32'h10) begin n_fail++; $display("FAIL hold_pc[%0d]: got %h exp %h", i, F_pc, 32'h10); end
      end
      F_ready = 1'b1;
      tick();
      n_cmp++; if (F_pc !== 32'h14) begin n_fail++; $display("FAIL hold_release: got %h exp %h", F_pc, 32'h14); end
   endtask

   task automatic test_priority();
      trap_req = 1'b1; trap_vec = 32'h100; EX_taken = 1'b1; EX_alt_pc = 32'h200;
      tick();
      clear_inputs();
      n_cmp++; if (F_pc !== 32'h100) begin n_fail++; $display("FAIL prio_pc: got %h exp %h", F_pc, 32'h100); end
      n_cmp++; if (F_flush !== 1'b1) begin n_fail++; $display("FAIL prio_flush: got %b exp 1", F_flush); end
      n_cmp++; if (redirect_cnt !== 4'd1) begin n_fail++; $display("FAIL prio_cnt: got %0d exp 1", redirect_cnt); end
      tick();
      n_cmp++; if (F_flush !== 1'b0) begin n_fail++; $display("FAIL prio_flush_drop: got %b exp 0", F_flush); end
      n_cmp++; if (F_pc !== 32'h104) begin n_fail++; $display("FAIL prio_next: got %h exp %h", F_pc, 32'h104); end
   endtask

   task automatic test_branch_stall();
      stall_D = 1'b1; EX_taken = 1'b1; EX_alt_pc = 32'h40;
      tick();
      EX_taken = 1'b0;
      n_cmp++; if (F_pc !== 32'h40) begin n_fail++; $display("FAIL br_stall_pc: got %h exp %h", F_pc, 32'h40); end
      n_cmp++; if (redirect_cnt !== 4'd2) begin n_fail++; $display("FAIL br_stall_cnt: got %0d exp 2", redirect_cnt); end
      tick();
      n_cmp++; if (F_pc !== 32'h40) begin n_fail++; $display("FAIL stall_hold: got %h exp %h", F_pc, 32'h40); end
      stall_D = 1'b0;
   endtask

   task automatic test_halt();
      EX_taken = 1'b1; EX_alt_pc = 32'h20;
      tick();
      EX_taken = 1'b0; halt_req = 1'b1;
      tick();
      n_cmp++; if (F_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid: got %b exp 0", F_valid); end
      n_cmp++; if (F_pc !== 32'h20) begin n_fail++; $display("FAIL halt_pc: got %h exp %h", F_pc, 32'h20); end
      n_cmp++; if (dbg_state !== PC_HALT) begin n_fail++; $display("FAIL halt_state: got %0d exp %0d", dbg_state, PC_HALT); end
      tick();
      n_cmp++; if (F_valid !== 1'b0 || F_pc !== 32'h20) begin n_fail++; $display("FAIL halt_stay: got %b/%h exp 0/%h", F_valid, F_pc, 32'h20); end
      EX_taken = 1'b1; EX_alt_pc = 32'h80;
      tick();
      EX_taken = 1'b0; halt_req = 1'b0;
      n_cmp++; if (F_valid !== 1'b1 || F_pc !== 32'h80) begin n_fail++; $display("FAIL halt_redirect: got %b/%h exp 1/%h", F_valid, F_pc, 32'h80); end
      n_cmp++; if (F_flush !== 1'b1) begin n_fail++; $display("FAIL halt_flush: got %b exp 1", F_flush); end
      tick();
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      tick();
      n_cmp++; if (F_valid !== 1'b1 || F_pc !== 32'h84) begin n_fail++; $display("FAIL halt_resume: got %b/%h exp 1/%h", F_valid, F_pc, 32'h84); end
      tick();
      n_cmp++; if (F_pc !== 32'h88) begin n_fail++; $display("FAIL halt_resume_step: got %h exp %h", F_pc, 32'h88); end
   endtask

   task automatic test_wrap_misalign();
      EX_taken = 1'b1; EX_alt_pc = 32'hFFFF_FFFC;
      tick();
      EX_taken = 1'b0;
      n_cmp++; if (F_pc_plus !== 32'h0) begin n_fail++; $display("FAIL wrap_plus: got %h exp %h", F_pc_plus, 32'h0); end
      tick();
      n_cmp++; if (F_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h exp %h", F_pc, 32'h0); end
      EX_taken = 1'b1; EX_alt_pc = 32'h42;
      tick();
      EX_taken = 1'b0;
      n_cmp++; if (F_pc !== 32'h42) begin n_fail++; $display("FAIL misalign_pc: got %h exp %h", F_pc, 32'h42); end
`ifdef PC_MISALIGN_CHECK_EN
      n_cmp++; if (F_misalign !== 1'b1) begin n_fail++; $display("FAIL misalign_set: got %b exp 1", F_misalign); end
`endif
      tick();
      n_cmp++; if (F_pc !== 32'h46) begin n_fail++; $display("FAIL misalign_step: got %h exp %h", F_pc, 32'h46); end
`ifdef PC_MISALIGN_CHECK_EN
      n_cmp++; if (F_misalign !== 1'b0) begin n_fail++; $display("FAIL misalign_clear: got %b exp 0", F_misalign); end
`endif
   endtask

   task automatic test_back_to_back();
      int start;
      int exp_cnt;
      start = 6;
      for (int i = 0; i < 12; i++) begin
         EX_taken = 1'b1; EX_alt_pc = {$urandom_range(0, 32'h0FFF_FFFF), 2'b00};
         tick();
         exp_cnt = (start + i + 1 > CMAX) ? CMAX : start + i + 1;
         n_cmp++; if (F_flush !== 1'b1) begin n_fail++; $display("FAIL b2b_flush[%0d]: got %b exp 1", i, F_flush); end
         n_cmp++; if (redirect_cnt !== 4'(exp_cnt)) begin n_fail++; $display("FAIL b2b_cnt[%0d]: got %0d exp %0d", i, redirect_cnt, exp_cnt); end
      end
      EX_taken = 1'b0;
      tick();
      n_cmp++; if (F_flush !== 1'b0 || redirect_cnt !== 4'd15) begin n_fail++; $display("FAIL b2b_end: got %b/%0d exp 0/15", F_flush, redirect_cnt); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         trap_req  = ($urandom_range(0, 9) == 0);
         EX_taken  = ($urandom_range(0, 7) == 0);
         stall_D   = ($urandom_range(0, 4) == 0);
         halt_req  = ($urandom_range(0, 7) == 0);
         F_ready   = ($urandom_range(0, 3) != 0);
         trap_vec  = $urandom();
         EX_alt_pc = $urandom();
         if ($urandom_range(0, 7) != 0) trap_vec[1:0] = 2'b00;
         if ($urandom_range(0, 7) != 0) EX_alt_pc[1:0] = 2'b00;
         tick();
         n_cmp++;
         if (F_pc !== m_pc || F_pc_plus !== m_pc + 32'd4 || F_valid !== m_valid ||
             F_flush !== m_flush || redirect_cnt !== 4'(m_cnt)) begin
            n_fail++;
            $display("FAIL rand[%0d]: got pc=%h plus=%h v=%b fl=%b cnt=%0d exp pc=%h plus=%h v=%b fl=%b cnt=%0d",
                     i, F_pc, F_pc_plus, F_valid, F_flush, redirect_cnt, m_pc, m_pc + 32'd4, m_valid, m_flush, m_cnt);
         end
`ifdef PC_MISALIGN_CHECK_EN
         n_cmp++; if (F_misalign !== m_mis) begin n_fail++; $display("FAIL rand_mis[%0d]: got %b exp %b", i, F_misalign, m_mis); end
`endif
      end
      clear_inputs();
   endtask

   task automatic test_midrun_reset();
      EX_taken = 1'b1; EX_alt_pc = 32'h300;
      tick();
      EX_taken = 1'b0;
      tick();
      #2 rst = 1'b0;
      #1;
      model_reset();
      n_cmp++; if (F_pc !== 32'h0) begin n_fail++; $display("FAIL arst_pc: got %h exp %h", F_pc, 32'h0); end
      n_cmp++; if (F_valid !== 1'b0 || F_flush !== 1'b0) begin n_fail++; $display("FAIL arst_vf: got %b/%b exp 0/0", F_valid, F_flush); end
      n_cmp++; if (redirect_cnt !== 4'd0) begin n_fail++; $display("FAIL arst_cnt: got %0d exp 0", redirect_cnt); end
      @(posedge clk);
      #1 rst = 1'b1;
      n_cmp++; if (F_valid !== 1'b0) begin n_fail++; $display("FAIL arst_boot: got %b exp 0", F_valid); end
      tick();
      n_cmp++; if (F_valid !== 1'b1 || F_pc !== 32'h0) begin n_fail++; $display("FAIL arst_run: got %b/%h exp 1/%h", F_valid, F_pc, 32'h0); end
      tick();
      n_cmp++; if (F_pc !== 32'h4) begin n_fail++; $display("FAIL arst_step: got %h exp %h", F_pc, 32'h4); end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_boot_seq();
      test_ready_hold();
      test_priority();
      test_branch_stall();
      test_halt();
      test_wrap_misalign();
      test_back_to_back();
      test_random();
      test_midrun_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
